// File: rtl/jtag_axi_txn_master.sv
// JTAG debug bridge AXI4-Lite master: pops {rnw,addr,wdata,wstrb}, runs one transaction, pushes {rdata,timeout,resp}.
// Latency: 4 cycles pop-to-push with an always-ready slave; exactly one transaction outstanding.
// Backpressure: holds in PUSH while the response FIFO is full; JTAG_AXI_TIMEOUT_EN adds an AXI stall abort.
module jtag_axi_txn_master #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                                        clk,
   input  logic                                        rst,
   input  logic                                        req_empty_i,
   input  logic [ADDR_WIDTH+DATA_WIDTH+DATA_WIDTH/8:0] req_data_i,
   output logic                                        req_pop_o,
   input  logic                                        resp_full_i,
   output logic                                        resp_push_o,
   output logic [DATA_WIDTH+2:0]                       resp_data_o,
   output logic [ADDR_WIDTH-1:0]                       m_awaddr,
   output logic [2:0]                                  m_awprot,
   output logic                                        m_awvalid,
   input  logic                                        m_awready,
   output logic [DATA_WIDTH-1:0]                       m_wdata,
   output logic [DATA_WIDTH/8-1:0]                     m_wstrb,
   output logic                                        m_wvalid,
   input  logic                                        m_wready,
   input  logic [1:0]                                  m_bresp,
   input  logic                                        m_bvalid,
   output logic                                        m_bready,
   output logic [ADDR_WIDTH-1:0]                       m_araddr,
   output logic [2:0]                                  m_arprot,
   output logic                                        m_arvalid,
   input  logic                                        m_arready,
   input  logic [DATA_WIDTH-1:0]                       m_rdata,
   input  logic [1:0]                                  m_rresp,
   input  logic                                        m_rvalid,
   output logic                                        m_rready,
   output logic                                        busy_o
);
   localparam int STRB_WIDTH = DATA_WIDTH / 8;
   localparam int REQ_WIDTH  = 1 + ADDR_WIDTH + DATA_WIDTH + STRB_WIDTH;

   if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_data_width
      $error("jtag_axi_txn_master: DATA_WIDTH must be 32 or 64");
   end
   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("jtag_axi_txn_master: TIMEOUT_CYCLES must be at least 2");
   end

   typedef enum logic [2:0] {
      IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, PUSH
   } state_t;

   state_t                 state, state_nxt;
   logic [REQ_WIDTH-2:0]   req_q;
   logic [DATA_WIDTH+2:0]  resp_q, resp_nxt;
   logic                   aw_done, w_done;
   logic                   run_q;
   logic                   timeout;

   // rnw is consumed at pop time, so only {addr, wdata, wstrb} is held
   assign m_awaddr    = req_q[REQ_WIDTH-2 -: ADDR_WIDTH];
   assign m_araddr    = req_q[REQ_WIDTH-2 -: ADDR_WIDTH];
   assign m_wdata     = req_q[STRB_WIDTH +: DATA_WIDTH];
   assign m_wstrb     = req_q[STRB_WIDTH-1:0];
   assign m_awprot    = 3'b000;
   assign m_arprot    = 3'b000;
   assign resp_data_o = resp_q;
   assign busy_o      = (state != IDLE);

`ifdef JTAG_AXI_TIMEOUT_EN
   localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_WIDTH-1:0] cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                             cnt <= '0;
      else if (state == IDLE || state == PUSH) cnt <= '0;
      else                                  cnt <= cnt + 1'b1;
   end

   // Fires on the last cycle valid/ready is still driven, so a handshake that cycle wins
   assign timeout = (cnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1));
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_nxt   = state;
      resp_nxt    = resp_q;
      req_pop_o   = 1'b0;
      resp_push_o = 1'b0;
      m_awvalid   = 1'b0;
      m_wvalid    = 1'b0;
      m_bready    = 1'b0;
      m_arvalid   = 1'b0;
      m_rready    = 1'b0;
      case (state)
         IDLE: begin
            if (run_q && !req_empty_i) begin
               req_pop_o = 1'b1;
               state_nxt = req_data_i[REQ_WIDTH-1] ? RD_ADDR : WR_ADDR_DATA;
            end
         end
         WR_ADDR_DATA: begin
            m_awvalid = !aw_done;
            m_wvalid  = !w_done;
            if ((aw_done || m_awready) && (w_done || m_wready)) begin
               state_nxt = WR_RESP;
            end else if (timeout) begin
               state_nxt = PUSH;
               resp_nxt  = {{DATA_WIDTH{1'b0}}, 1'b1, 2'b10};
            end
         end
         WR_RESP: begin
            m_bready = 1'b1;
            if (m_bvalid) begin
               state_nxt = PUSH;
               resp_nxt  = {{DATA_WIDTH{1'b0}}, 1'b0, m_bresp};
            end else if (timeout) begin
               state_nxt = PUSH;
               resp_nxt  = {{DATA_WIDTH{1'b0}}, 1'b1, 2'b10};
            end
         end
         RD_ADDR: begin
            m_arvalid = 1'b1;
            if (m_arready) begin
               state_nxt = RD_DATA;
            end else if (timeout) begin
               state_nxt = PUSH;
               resp_nxt  = {{DATA_WIDTH{1'b0}}, 1'b1, 2'b10};
            end
         end
         RD_DATA: begin
            m_rready = 1'b1;
            if (m_rvalid) begin
               state_nxt = PUSH;
               resp_nxt  = {m_rdata, 1'b0, m_rresp};
            end else if (timeout) begin
               state_nxt = PUSH;
               resp_nxt  = {{DATA_WIDTH{1'b0}}, 1'b1, 2'b10};
            end
         end
         PUSH: begin
            if (!resp_full_i) begin
               resp_push_o = 1'b1;
               state_nxt   = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // run_q keeps the pop strobe low while reset is asserted without using rst combinationally
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         req_q   <= '0;
         resp_q  <= '0;
         aw_done <= 1'b0;
         w_done  <= 1'b0;
         run_q   <= 1'b0;
      end else begin
         state  <= state_nxt;
         resp_q <= resp_nxt;
         run_q  <= 1'b1;
         if (req_pop_o) req_q <= req_data_i[REQ_WIDTH-2:0];
         if (state != WR_ADDR_DATA) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
         end else begin
            if (m_awvalid && m_awready) aw_done <= 1'b1;
            if (m_wvalid && m_wready)   w_done  <= 1'b1;
         end
      end
   end
endmodule

// File: doc/jtag_axi_txn_master.md
Name: jtag_axi_txn_master

Overview:
- Downstream consumer of the JTAG request FIFO. Pops one packed request per transaction and executes it as a single AXI4-Lite read or write.
- Pushes one packed response per request into the response FIFO, which the JTAG DR shift path reads back.
- Exactly one transaction is outstanding at a time. Sits in the AXI clock domain.

Parameters:
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 32, AXI data width; must be 32 or 64.
- TIMEOUT_CYCLES, 4096, abort threshold in cycles; used only with JTAG_AXI_TIMEOUT_EN.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- req_empty_i  in  1  request FIFO empty.
- req_data_i  in  1+ADDR_WIDTH+DATA_WIDTH+DATA_WIDTH/8  request, packed {rnw, addr, wdata, wstrb}; valid same cycle (async-read FIFO).
- req_pop_o  out  1  request FIFO read strobe.
- resp_full_i  in  1  response FIFO full.
- resp_push_o  out  1  response FIFO write strobe.
- resp_data_o  out  DATA_WIDTH+3  response, packed {rdata, timeout, resp[1:0]}.
- m_awaddr/m_awvalid/m_awready, m_wdata/m_wstrb/m_wvalid/m_wready, m_bresp/m_bvalid/m_bready, m_araddr/m_arvalid/m_arready, m_rdata/m_rresp/m_rvalid/m_rready  AXI4-Lite master, standard widths and directions; awprot and arprot are tied to 3'b000.
- busy_o  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst=0, asynchronous): FSM goes to IDLE. All valid, ready, pop and push outputs are 0. Captured request and response registers are 0. An in-flight transaction is dropped with no response.
- States: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, PUSH.
- IDLE, when req_empty_i=0:
  - req_pop_o=1 for exactly 1 cycle.
  - req_data_i is captured in the same cycle.
  - Next state is RD_ADDR if rnw=1, otherwise WR_ADDR_DATA.
  - req_pop_o is never asserted while req_empty_i=1.
- WR_ADDR_DATA:
  - m_awvalid and m_wvalid rise together on entry.
  - Each drops the cycle after its own handshake; the two handshakes are tracked independently with per-channel done flags.
  - Move to WR_RESP once both are done; if both handshakes occur in the same cycle, move directly.
  - Address, data and strobe stay stable while valid is high.
- WR_RESP: m_bready=1. On m_bvalid, capture bresp, set rdata field to 0, move to PUSH.
- RD_ADDR: m_arvalid=1 until m_arready, then move to RD_DATA.
- RD_DATA: m_rready=1. On m_rvalid, capture rdata and rresp, move to PUSH.
- PUSH:
  - resp_push_o=1 only when resp_full_i=0, then go to IDLE.
  - While resp_full_i=1, hold in PUSH with resp_data_o stable.
  - No new request is popped until the push completes.
- Minimum latency with all AXI ready/valid signals high: write pop to push is 4 cycles (IDLE, WR_ADDR_DATA, WR_RESP, PUSH); read is the same.
- The next pop can occur in the cycle after the push.
- Back-to-back throughput is 1 transaction per 4 cycles.
- resp_data_o is registered and holds its last value outside PUSH.
- Unsupported or ignored inputs: bvalid/rvalid arriving outside their states are ignored (bready/rready are 0). wstrb=0 is passed through unchanged.

Optional Feature:
- Macro: JTAG_AXI_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in every AXI state and clears on entry to IDLE.
  - When the count reaches TIMEOUT_CYCLES, all AXI valid/ready signals drop and the FSM moves to PUSH.
  - The response is timeout=1, resp=2'b10, rdata=0.
  - Dropping a valid before its handshake is a deliberate debug-bridge recovery and is documented as non-compliant.
  - A handshake in the same cycle as the timeout wins: the normal response is pushed.
- Not defined: no counter; the FSM waits indefinitely; the timeout bit is always 0.

Test Plan:
- Write, all ready: request {0, 0x1000, 0xDEADBEEF, 0xF}, bresp=OKAY.
  - Expect one req_pop_o pulse; awaddr=0x1000, wdata=0xDEADBEEF, wstrb=0xF.
  - Push {0, 0, 2'b00} exactly 4 cycles after the pop.
- Read: request {1, 0x2004, x, x}; rdata=0xCAFEF00D returned with rresp=SLVERR after 3 stall cycles.
  - Expect push {0xCAFEF00D, 0, 2'b10}.
- Skewed write handshakes: awready at cycle 1, wready at cycle 5.
  - awvalid drops after cycle 1; wvalid held through cycle 5; only one B handshake; one push.
- Response backpressure: resp_full_i=1 for 10 cycles in PUSH while a second request waits.
  - resp_data_o is stable, no pop, single push when full clears, second pop the next cycle.
- Reset mid-read: rst=0 in RD_DATA.
  - All outputs 0 immediately; after release, the next request is popped and no stale push occurs.
- With JTAG_AXI_TIMEOUT_EN and TIMEOUT_CYCLES=16: slave never asserts arready.
  - arvalid drops at cycle 16; push {0, 1, 2'b10}; then return to IDLE.
